tile_launch_ctrl: RTL and testbench

TILE_LAUNCH_CTRL -- requirements
Module: tile_launch_ctrl

---
 rtl/tile_ctrl_pkg.sv | 25 ++
 rtl/tile_hs_slice.sv | 68 ++++++
 rtl/tile_launch_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_tile_launch_ctrl.sv | 509 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_ctrl_pkg.sv
// Shared definitions for the tile launch controller.
//   - default parameter values used by tile_launch_ctrl
//   - the controller state encoding
//   - tmo_width(): counter width needed to count up to timeout-1
package tile_ctrl_pkg;

  localparam int DEF_TILE    = 4;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_TIMEOUT = 1024;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_DONE = 3'd2,
    DRAIN     = 3'd3,
    NEXT      = 3'd4,
    ERROR     = 3'd5
  } state_t;

  // Width of a counter that must reach timeout-1; never narrower than 1 bit.
  function automatic int tmo_width(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/tile_hs_slice.sv
// Per-tile handshake bookkeeping for the tile launch controller.
// Keeps three sticky bits for one tile: started (ap_ready seen), done
// (ap_done seen) and drained (PE result consumed).
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   enable              tile is part of the current command
//   launch              controller is in START
//   drain               controller is in DRAIN
//   capture             controller is busy (ap_done may be recorded)
//   clear               synchronous clear of all sticky bits
//   ap_ready, ap_done   tile handshake inputs
//   pe_output_valid     PE result available
//   ap_start            start request to the tile
//   pe_output_taken     one-cycle result-consumed pulse
//   started_seen, done_seen, drained_seen
//                       sticky bit OR this cycle's event, so the
//                       controller can react in the same cycle
module tile_hs_slice (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic launch,
  input  logic drain,
  input  logic capture,
  input  logic clear,
  input  logic ap_ready,
  input  logic ap_done,
  input  logic pe_output_valid,
  output logic ap_start,
  output logic pe_output_taken,
  output logic started_seen,
  output logic done_seen,
  output logic drained_seen
);

  logic started_q;
  logic done_q;
  logic drained_q;

  // Start is requested until the tile has accepted it; once the drained bit
  // is set the taken pulse stops by itself, which keeps it one cycle wide.
  always_comb begin
    ap_start        = launch & enable & ~started_q;
    pe_output_taken = drain & enable & ~drained_q & pe_output_valid;
    started_seen    = started_q | (ap_start & ap_ready);
    done_seen       = done_q | (capture & ap_done);
    drained_seen    = drained_q | pe_output_taken;
  end

  // Sticky bits: clear has priority so a done arriving in the clearing
  // cycle is deliberately dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      started_q <= 1'b0;
      done_q    <= 1'b0;
      drained_q <= 1'b0;
    end else if (clear) begin
      started_q <= 1'b0;
      done_q    <= 1'b0;
      drained_q <= 1'b0;
    end else begin
      started_q <= started_seen;
      done_q    <= done_seen;
      drained_q <= drained_seen;
    end
  end

endmodule

// File: rtl/tile_launch_ctrl.sv
// Tile launch controller: runs a command of N iterations over a set of
// tiles. Each iteration starts the masked tiles (ap_ctrl_hs initiator),
// waits for all of them to finish, consumes one PE result per tile, then
// either repeats or reports completion with done_pulse.
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake (ready only in IDLE)
//   cmd_tile_mask               tiles taking part
//   cmd_iterations              launches per command
//   cmd_abort                   return to IDLE on the next edge
//   ap_start/ap_ready/ap_done   per-tile start handshake and completion
//   pe_output_valid/_taken      per-tile result handshake
//   busy, done_pulse, error     status
//   err_tile_mask               tiles that stalled when ERROR was entered
//   iter_count                  iterations completed for this command
module tile_launch_ctrl
  import tile_ctrl_pkg::*;
#(
  parameter int TILE    = DEF_TILE,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [TILE-1:0]  cmd_tile_mask,
  input  logic [CNT_W-1:0] cmd_iterations,
  input  logic             cmd_abort,
  output logic [TILE-1:0]  ap_start,
  input  logic [TILE-1:0]  ap_ready,
  input  logic [TILE-1:0]  ap_done,
  input  logic [TILE-1:0]  pe_output_valid,
  output logic [TILE-1:0]  pe_output_taken,
  output logic             busy,
  output logic             done_pulse,
  output logic             error,
  output logic [TILE-1:0]  err_tile_mask,
  output logic [CNT_W-1:0] iter_count
);

  localparam int TMO_W = tmo_width(TIMEOUT);

  state_t           state_q;
  state_t           state_d;
  logic [TILE-1:0]  mask_q;
  logic [CNT_W-1:0] iter_q;
  logic [CNT_W-1:0] iter_count_q;
  logic [CNT_W-1:0] iter_inc;
  logic [TMO_W-1:0] tmo_q;
  logic [TILE-1:0]  err_mask_q;
  logic             done_pulse_q;

  logic [TILE-1:0]  started_seen;
  logic [TILE-1:0]  done_seen;
  logic [TILE-1:0]  drained_seen;

  logic             accept;
  logic             zero_cmd;
  logic             all_started;
  logic             all_done;
  logic             all_drained;
  logic             tmo_hit;
  logic             last_iter;
  logic             launch;
  logic             drain;
  logic             capture;
  logic             slice_clear;

  // Per-tile handshake slices.
  for (genvar g = 0; g < TILE; g++) begin : g_tile
    tile_hs_slice u_slice (
      .clk             (clk),
      .reset           (reset),
      .enable          (mask_q[g]),
      .launch          (launch),
      .drain           (drain),
      .capture         (capture),
      .clear           (slice_clear),
      .ap_ready        (ap_ready[g]),
      .ap_done         (ap_done[g]),
      .pe_output_valid (pe_output_valid[g]),
      .ap_start        (ap_start[g]),
      .pe_output_taken (pe_output_taken[g]),
      .started_seen    (started_seen[g]),
      .done_seen       (done_seen[g]),
      .drained_seen    (drained_seen[g])
    );
  end

  // Condition decode. The *_seen vectors include this cycle's events, so
  // e.g. an ap_done arriving together with the last ap_ready lets START jump
  // straight to DRAIN. A zero mask or zero iteration count is completed
  // without ever leaving IDLE.
  always_comb begin
    accept      = cmd_valid & (state_q == IDLE) & ~cmd_abort;
    zero_cmd    = (cmd_tile_mask == '0) || (cmd_iterations == '0);
    all_started = (started_seen & mask_q) == mask_q;
    all_done    = (done_seen & mask_q) == mask_q;
    all_drained = (drained_seen & mask_q) == mask_q;
    tmo_hit     = (tmo_q == TMO_W'(TIMEOUT - 1));
    iter_inc    = iter_count_q + 1'b1;
    last_iter   = (iter_inc == iter_q);
    launch      = (state_q == START);
    drain       = (state_q == DRAIN);
    capture     = (state_q != IDLE);
    slice_clear = cmd_abort || (state_q == IDLE) || (state_q == NEXT);
  end

  // Next-state logic. Abort overrides every other transition; ERROR is only
  // left through abort or reset.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (accept && !zero_cmd) state_d = START;
      START:     if (all_started) state_d = all_done ? DRAIN : WAIT_DONE;
      WAIT_DONE: if (all_done) state_d = DRAIN;
                 else if (tmo_hit) state_d = ERROR;
      DRAIN:     if (all_drained) state_d = NEXT;
                 else if (tmo_hit) state_d = ERROR;
      NEXT:      state_d = last_iter ? IDLE : START;
      ERROR:     state_d = ERROR;
      default:   state_d = IDLE;
    endcase
    if (cmd_abort) state_d = IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Command latch, iteration counter, completion pulse and error capture.
  // The stalled-tile mask is taken from the same vectors that decided the
  // exit condition was not met.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_q       <= '0;
      iter_q       <= '0;
      iter_count_q <= '0;
      err_mask_q   <= '0;
      done_pulse_q <= 1'b0;
    end else begin
      done_pulse_q <= 1'b0;
      if (cmd_abort) begin
        iter_count_q <= '0;
        err_mask_q   <= '0;
      end else begin
        case (state_q)
          IDLE: if (accept) begin
            mask_q       <= cmd_tile_mask;
            iter_q       <= cmd_iterations;
            iter_count_q <= '0;
            done_pulse_q <= zero_cmd;
          end
          WAIT_DONE: if (state_d == ERROR) err_mask_q <= mask_q & ~done_seen;
          DRAIN:     if (state_d == ERROR) err_mask_q <= mask_q & ~drained_seen;
          NEXT: begin
            iter_count_q <= iter_inc;
            done_pulse_q <= last_iter;
          end
          default: ;
        endcase
      end
    end
  end

  // Timeout counter: restarts whenever WAIT_DONE or DRAIN is entered and
  // counts the cycles spent there.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_q <= '0;
    end else if (cmd_abort) begin
      tmo_q <= '0;
    end else if ((state_d == WAIT_DONE || state_d == DRAIN) && state_d != state_q) begin
      tmo_q <= '0;
    end else if (state_q == WAIT_DONE || state_q == DRAIN) begin
      tmo_q <= tmo_q + 1'b1;
    end
  end

  // Status outputs.
  always_comb begin
    cmd_ready     = (state_q == IDLE);
    busy          = (state_q != IDLE);
    error         = (state_q == ERROR);
    done_pulse    = done_pulse_q;
    err_tile_mask = err_mask_q;
    iter_count    = iter_count_q;
  end

endmodule

// File: tb/tb_tile_launch_ctrl.sv
// Directed self-checking bench for tile_launch_ctrl (TILE=4, CNT_W=16,
// TIMEOUT=16). A behavioural tile model answers ap_start with configurable
// ready/done/valid delays; a monitor counts output events on the falling
// edge; each test task drives one scenario and compares against
// hand-computed values.
module tb_tile_launch_ctrl;
  import tile_ctrl_pkg::*;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_tile_mask;
  logic [15:0] cmd_iterations;
  logic        cmd_abort;
  logic [3:0]  ap_start;
  logic [3:0]  ap_ready;
  logic [3:0]  ap_done;
  logic [3:0]  pe_output_valid;
  logic [3:0]  pe_output_taken;
  logic        busy;
  logic        done_pulse;
  logic        error;
  logic [3:0]  err_tile_mask;
  logic [15:0] iter_count;

  int checks = 0;
  int fails  = 0;

  // Tile model configuration (written only by the stimulus process).
  bit         ready_tie;
  int         ready_delay [4];
  int         done_delay;
  int         valid_delay;
  logic [3:0] done_en;

  // Tile model state (written only by the model process).
  int   age [4];
  int   dtimer [4];
  int   vtimer [4];
  int   taken_ack [4];
  logic model_hs;

  // Monitor counters (written only by the monitor process).
  int         mon_start_cycles [4];
  int         mon_start_rises [4];
  int         mon_taken [4];
  int         mon_done;
  int         mon_wait;
  int         mon_stray;
  logic [3:0] prev_start;

  // Snapshots taken by the tests.
  int b_sc [4];
  int b_sr [4];
  int b_tk [4];
  int b_done;
  int b_wait;
  int b_stray;

  tile_launch_ctrl #(.TILE(4), .CNT_W(16), .TIMEOUT(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_tile_mask   (cmd_tile_mask),
    .cmd_iterations  (cmd_iterations),
    .cmd_abort       (cmd_abort),
    .ap_start        (ap_start),
    .ap_ready        (ap_ready),
    .ap_done         (ap_done),
    .pe_output_valid (pe_output_valid),
    .pe_output_taken (pe_output_taken),
    .busy            (busy),
    .done_pulse      (done_pulse),
    .error           (error),
    .err_tile_mask   (err_tile_mask),
    .iter_count      (iter_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Tile model, evaluated just after each rising edge. Per tile: ready after
  // ready_delay cycles of ap_start (or always, when tied), a done pulse
  // done_delay cycles after the handshake, and valid raised valid_delay
  // cycles after done and held until a taken pulse has been counted.
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      ap_ready        = '0;
      ap_done         = '0;
      pe_output_valid = '0;
      for (int i = 0; i < 4; i++) begin
        age[i]       = 0;
        dtimer[i]    = -1;
        vtimer[i]    = -1;
        taken_ack[i] = mon_taken[i];
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (mon_taken[i] != taken_ack[i]) begin
          pe_output_valid[i] = 1'b0;
          taken_ack[i]       = mon_taken[i];
        end
        if (ap_start[i]) begin
          ap_ready[i] = ready_tie || (age[i] >= ready_delay[i]);
          age[i]      = age[i] + 1;
        end else begin
          ap_ready[i] = ready_tie;
          age[i]      = 0;
        end
        model_hs   = ap_start[i] && ap_ready[i];
        ap_done[i] = 1'b0;
        if (model_hs && done_en[i]) dtimer[i] = done_delay;
        if (dtimer[i] == 0) begin
          ap_done[i] = 1'b1;
          vtimer[i]  = valid_delay;
        end
        if (dtimer[i] >= 0) dtimer[i] = dtimer[i] - 1;
        if (vtimer[i] == 0) pe_output_valid[i] = 1'b1;
        if (vtimer[i] >= 0) vtimer[i] = vtimer[i] - 1;
      end
    end
  end

  // Monitor on the falling edge: cumulative event counters.
  always @(negedge clk) begin
    if (!reset) begin
      prev_start = '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (ap_start[i]) begin
          mon_start_cycles[i] = mon_start_cycles[i] + 1;
          if (!prev_start[i]) mon_start_rises[i] = mon_start_rises[i] + 1;
        end
        if (pe_output_taken[i]) mon_taken[i] = mon_taken[i] + 1;
      end
      prev_start = ap_start;
      if (done_pulse) mon_done = mon_done + 1;
      if (dut.state_q == WAIT_DONE) mon_wait = mon_wait + 1;
      if (pe_output_taken != '0 && dut.state_q != DRAIN) mon_stray = mon_stray + 1;
    end
  end

  task automatic snapshot();
    for (int i = 0; i < 4; i++) begin
      b_sc[i] = mon_start_cycles[i];
      b_sr[i] = mon_start_rises[i];
      b_tk[i] = mon_taken[i];
    end
    b_done  = mon_done;
    b_wait  = mon_wait;
    b_stray = mon_stray;
  endtask

  task automatic set_model(input bit tie, input int r2, input int dd, input int vd,
                           input logic [3:0] den);
    ready_tie = tie;
    for (int i = 0; i < 4; i++) ready_delay[i] = 0;
    ready_delay[2] = r2;
    done_delay     = dd;
    valid_delay    = vd;
    done_en        = den;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic issue_cmd(input logic [3:0] m, input logic [15:0] n);
    cmd_tile_mask  = m;
    cmd_iterations = n;
    cmd_valid      = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < bound && !seen; k++) begin
      @(posedge clk);
      #1;
      if (mon_done != b_done) seen = 1'b1;
    end
  endtask

  task automatic wait_state(input state_t s, input int bound, output bit seen);
    seen = (dut.state_q == s);
    for (int k = 0; k < bound && !seen; k++) begin
      @(posedge clk);
      #1;
      if (dut.state_q == s) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({busy, cmd_ready, done_pulse, error} !== 4'b0100) begin
      fails++;
      $display("[TB] FAIL reset_status: got %b expected 0100", {busy, cmd_ready, done_pulse, error});
    end
    checks++;
    if ({ap_start, pe_output_taken, err_tile_mask} !== 12'h000) begin
      fails++;
      $display("[TB] FAIL reset_vectors: got %h expected 000", {ap_start, pe_output_taken, err_tile_mask});
    end
    checks++;
    if (iter_count !== 16'd0) begin
      fails++;
      $display("[TB] FAIL reset_iter_count: got %0d expected 0", iter_count);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_four_tile_two_iter();
    bit seen;
    int tk;
    do_reset();
    set_model(1'b1, 0, 5, 2, 4'b1111);
    snapshot();
    issue_cmd(4'b1111, 16'd2);
    wait_done(100, seen);
    checks++;
    if (!seen) begin
      fails++;
      $display("[TB] FAIL two_iter_done_timeout: got no done_pulse expected one within 100 cycles");
    end
    repeat (5) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mon_start_rises[i] - b_sr[i] != 2) begin
        fails++;
        $display("[TB] FAIL two_iter_start_pulses tile %0d: got %0d expected 2", i, mon_start_rises[i] - b_sr[i]);
      end
    end
    tk = 0;
    for (int i = 0; i < 4; i++) tk += mon_taken[i] - b_tk[i];
    checks++;
    if (tk != 8) begin
      fails++;
      $display("[TB] FAIL two_iter_taken: got %0d expected 8", tk);
    end
    checks++;
    if (mon_done - b_done != 1) begin
      fails++;
      $display("[TB] FAIL two_iter_done_count: got %0d expected 1", mon_done - b_done);
    end
    checks++;
    if (iter_count !== 16'd2) begin
      fails++;
      $display("[TB] FAIL two_iter_iter_count: got %0d expected 2", iter_count);
    end
    checks++;
    if (mon_stray != b_stray) begin
      fails++;
      $display("[TB] FAIL two_iter_stray_taken: got %0d expected 0", mon_stray - b_stray);
    end
  endtask

  task automatic test_ready_delay();
    bit seen;
    int exp_cycles [4];
    exp_cycles[0] = 1;
    exp_cycles[1] = 0;
    exp_cycles[2] = 8;
    exp_cycles[3] = 0;
    do_reset();
    set_model(1'b0, 7, 1, 0, 4'b1111);
    snapshot();
    issue_cmd(4'b0101, 16'd1);
    wait_done(100, seen);
    checks++;
    if (!seen) begin
      fails++;
      $display("[TB] FAIL ready_delay_done_timeout: got no done_pulse expected one within 100 cycles");
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mon_start_cycles[i] - b_sc[i] != exp_cycles[i]) begin
        fails++;
        $display("[TB] FAIL ready_delay_start_cycles tile %0d: got %0d expected %0d",
                 i, mon_start_cycles[i] - b_sc[i], exp_cycles[i]);
      end
    end
  endtask

  task automatic test_timeout_error();
    bit seen;
    do_reset();
    set_model(1'b1, 0, 5, 2, 4'b0111);
    snapshot();
    issue_cmd(4'b1111, 16'd1);
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (error === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      fails++;
      $display("[TB] FAIL timeout_no_error: got error=%b expected 1 within 60 cycles", error);
    end
    checks++;
    if (mon_wait - b_wait != 16) begin
      fails++;
      $display("[TB] FAIL timeout_wait_cycles: got %0d expected 16", mon_wait - b_wait);
    end
    checks++;
    if (err_tile_mask !== 4'b1000) begin
      fails++;
      $display("[TB] FAIL timeout_err_mask: got %b expected 1000", err_tile_mask);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if ({error, busy, cmd_ready, ap_start, pe_output_taken} !== 11'b110_0000_0000) begin
      fails++;
      $display("[TB] FAIL timeout_error_hold: got %b expected 11000000000",
               {error, busy, cmd_ready, ap_start, pe_output_taken});
    end
    checks++;
    if (mon_done != b_done || mon_stray != b_stray) begin
      fails++;
      $display("[TB] FAIL timeout_spurious: got done=%0d stray=%0d expected 0 0",
               mon_done - b_done, mon_stray - b_stray);
    end
    cmd_abort = 1'b1;
    @(posedge clk);
    #1 cmd_abort = 1'b0;
    checks++;
    if ({error, err_tile_mask, busy, cmd_ready} !== 7'b0_0000_01) begin
      fails++;
      $display("[TB] FAIL timeout_abort_clear: got %b expected 0000001",
               {error, err_tile_mask, busy, cmd_ready});
    end
  endtask

  task automatic test_done_with_ready();
    bit seen;
    int tk;
    do_reset();
    set_model(1'b1, 0, 0, 0, 4'b1111);
    snapshot();
    issue_cmd(4'b1111, 16'd1);
    wait_done(50, seen);
    checks++;
    if (!seen) begin
      fails++;
      $display("[TB] FAIL coincident_done_timeout: got no done_pulse expected one within 50 cycles");
    end
    checks++;
    if (mon_wait != b_wait) begin
      fails++;
      $display("[TB] FAIL coincident_wait_cycles: got %0d expected 0", mon_wait - b_wait);
    end
    tk = 0;
    for (int i = 0; i < 4; i++) tk += mon_taken[i] - b_tk[i];
    checks++;
    if (tk != 4) begin
      fails++;
      $display("[TB] FAIL coincident_taken: got %0d expected 4", tk);
    end
  endtask

  task automatic test_zero_commands();
    int sc;
    do_reset();
    set_model(1'b1, 0, 1, 0, 4'b1111);
    snapshot();
    issue_cmd(4'b1111, 16'd0);
    checks++;
    if ({done_pulse, busy, cmd_ready} !== 3'b101) begin
      fails++;
      $display("[TB] FAIL zero_iter_pulse: got %b expected 101", {done_pulse, busy, cmd_ready});
    end
    @(posedge clk);
    #1;
    checks++;
    if (done_pulse !== 1'b0) begin
      fails++;
      $display("[TB] FAIL zero_iter_pulse_width: got %b expected 0", done_pulse);
    end
    issue_cmd(4'b0000, 16'd3);
    checks++;
    if ({done_pulse, busy, cmd_ready} !== 3'b101) begin
      fails++;
      $display("[TB] FAIL zero_mask_pulse: got %b expected 101", {done_pulse, busy, cmd_ready});
    end
    repeat (3) @(posedge clk);
    #1;
    sc = 0;
    for (int i = 0; i < 4; i++) sc += mon_start_cycles[i] - b_sc[i];
    checks++;
    if (sc != 0 || mon_done - b_done != 2) begin
      fails++;
      $display("[TB] FAIL zero_cmd_activity: got starts=%0d done=%0d expected 0 2", sc, mon_done - b_done);
    end
  endtask

  task automatic test_reset_in_drain();
    bit seen;
    do_reset();
    set_model(1'b1, 0, 2, 8, 4'b1111);
    snapshot();
    issue_cmd(4'b1111, 16'd2);
    wait_state(DRAIN, 50, seen);
    checks++;
    if (!seen) begin
      fails++;
      $display("[TB] FAIL reset_drain_reach: got state %0d expected DRAIN within 50 cycles", dut.state_q);
    end
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    checks++;
    if ({busy, cmd_ready, done_pulse, error, ap_start, pe_output_taken, err_tile_mask} !== 16'h4000) begin
      fails++;
      $display("[TB] FAIL reset_drain_outputs: got %h expected 4000",
               {busy, cmd_ready, done_pulse, error, ap_start, pe_output_taken, err_tile_mask});
    end
    checks++;
    if (iter_count !== 16'd0) begin
      fails++;
      $display("[TB] FAIL reset_drain_iter_count: got %0d expected 0", iter_count);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (mon_done != b_done || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_drain_abandon: got done=%0d busy=%b expected 0 0", mon_done - b_done, busy);
    end
  endtask

  task automatic test_abort_in_wait();
    bit seen;
    do_reset();
    set_model(1'b1, 0, 8, 1, 4'b1111);
    snapshot();
    issue_cmd(4'b0011, 16'd1);
    wait_state(WAIT_DONE, 50, seen);
    checks++;
    if (!seen) begin
      fails++;
      $display("[TB] FAIL abort_wait_reach: got state %0d expected WAIT_DONE within 50 cycles", dut.state_q);
    end
    @(posedge clk);
    #1 cmd_abort = 1'b1;
    checks++;
    if ({busy, cmd_ready} !== 2'b10) begin
      fails++;
      $display("[TB] FAIL abort_before_edge: got %b expected 10", {busy, cmd_ready});
    end
    @(posedge clk);
    #1 cmd_abort = 1'b0;
    checks++;
    if ({busy, cmd_ready, done_pulse, error, ap_start, pe_output_taken, err_tile_mask} !== 16'h4000) begin
      fails++;
      $display("[TB] FAIL abort_outputs: got %h expected 4000",
               {busy, cmd_ready, done_pulse, error, ap_start, pe_output_taken, err_tile_mask});
    end
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (mon_done != b_done || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL abort_no_done: got done=%0d busy=%b expected 0 0", mon_done - b_done, busy);
    end
  endtask

  // Safety net in case a wait is missed.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish expected end of test before 500000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset          = 1'b0;
    cmd_valid      = 1'b0;
    cmd_abort      = 1'b0;
    cmd_tile_mask  = '0;
    cmd_iterations = '0;
    set_model(1'b0, 0, 1, 0, 4'b1111);
    $display("[TB] tile_launch_ctrl directed tests start");
    test_reset();
    test_four_tile_two_iter();
    test_ready_delay();
    test_timeout_error();
    test_done_with_ready();
    test_zero_commands();
    test_reset_in_drain();
    test_abort_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
